// File: rtl/pool_pkg.sv
// Shared state encoding and counter-width helpers for the pooling window scheduler.
package pool_pkg;

  typedef enum logic [1:0] {
    LOAD = 2'd0,
    SCAN = 2'd1,
    EMIT = 2'd2
  } pool_state_t;

  // Width needed to count n distinct values; never narrower than one bit.
  function automatic int cnt_w(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

  localparam int DEF_DEPTH = 8;
  localparam int DEF_KX    = 3;
  localparam int DEF_KY    = 3;
  localparam int DEF_AX    = 8;
  localparam int DEF_AY    = 8;

  localparam int DEF_LOAD_W = cnt_w(DEF_AX * DEF_AY);
  localparam int DEF_WIN_XW = cnt_w(DEF_AX - DEF_KX + 1);
  localparam int DEF_WIN_YW = cnt_w(DEF_AY - DEF_KY + 1);
  localparam int DEF_KER_XW = cnt_w(DEF_KX);
  localparam int DEF_KER_YW = cnt_w(DEF_KY);

endpackage

// File: rtl/pool_max_acc.sv
// Running unsigned maximum: start loads the first element, later elements replace
// the held value only when strictly greater.
module pool_max_acc
  import pool_pkg::*;
#(
  parameter int DEPTH = DEF_DEPTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             start,
  input  logic [DEPTH-1:0] din,
  output logic [DEPTH-1:0] max_out
);

  logic [DEPTH-1:0] max_q;
  logic [DEPTH-1:0] max_d;

  always_comb begin
    max_d = max_q;
    if (en) begin
      if (start || (din > max_q)) begin
        max_d = din;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      max_q <= '0;
    end else begin
      max_q <= max_d;
    end
  end

  assign max_out = max_q;

endmodule

// File: rtl/pool_window_scheduler.sv
// Buffers one raster frame, then scans every KX x KY window one element per cycle
// and emits its maximum over a valid/ready handshake.
module pool_window_scheduler
  import pool_pkg::*;
#(
  parameter int DEPTH = DEF_DEPTH,
  parameter int KX    = DEF_KX,
  parameter int KY    = DEF_KY,
  parameter int AX    = DEF_AX,
  parameter int AY    = DEF_AY
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [DEPTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [DEPTH-1:0] out_data,
  output logic             out_last,
  output logic             busy
);

  localparam int NPIX = AX * AY;
  localparam int LW   = cnt_w(NPIX);
  localparam int IW   = cnt_w(AX - KX + 1);
  localparam int JW   = cnt_w(AY - KY + 1);
  localparam int XW   = cnt_w(KX);
  localparam int YW   = cnt_w(KY);

  localparam logic [LW-1:0] LOAD_LAST = LW'(NPIX - 1);
  localparam logic [IW-1:0] I_LAST    = IW'(AX - KX);
  localparam logic [JW-1:0] J_LAST    = JW'(AY - KY);
  localparam logic [XW-1:0] L_LAST    = XW'(KX - 1);
  localparam logic [YW-1:0] M_LAST    = YW'(KY - 1);

  pool_state_t      state_q, state_d;
  logic [LW-1:0]    load_cnt_q, load_cnt_d;
  logic [IW-1:0]    i_q, i_d;
  logic [JW-1:0]    j_q, j_d;
  logic [XW-1:0]    l_q, l_d;
  logic [YW-1:0]    m_q, m_d;

  logic [DEPTH-1:0] fb_q [NPIX];
  logic             wr_en;
  logic [LW-1:0]    rd_addr;
  logic             acc_en;
  logic             acc_start;
  logic [DEPTH-1:0] acc_max;
  logic             last_win;

  assign last_win = (i_q == I_LAST) && (j_q == J_LAST);
  // Element (x,y) = (i+l, j+m) lives at raster address y*AX + x.
  assign rd_addr  = LW'((int'(j_q) + int'(m_q)) * AX + int'(i_q) + int'(l_q));

  always_comb begin
    state_d    = state_q;
    load_cnt_d = load_cnt_q;
    i_d        = i_q;
    j_d        = j_q;
    l_d        = l_q;
    m_d        = m_q;
    wr_en      = 1'b0;
    acc_en     = 1'b0;
    acc_start  = 1'b0;
    case (state_q)
      LOAD: begin
        if (in_valid) begin
          wr_en = 1'b1;
          if (load_cnt_q == LOAD_LAST) begin
            state_d = SCAN;
          end else begin
            load_cnt_d = load_cnt_q + 1'b1;
          end
        end
      end
      SCAN: begin
        acc_en    = 1'b1;
        acc_start = (l_q == '0) && (m_q == '0);
        if (m_q == M_LAST) begin
          m_d = '0;
          if (l_q == L_LAST) begin
            l_d     = '0;
            state_d = EMIT;
          end else begin
            l_d = l_q + 1'b1;
          end
        end else begin
          m_d = m_q + 1'b1;
        end
      end
      EMIT: begin
        if (out_ready) begin
          if (last_win) begin
            state_d    = LOAD;
            load_cnt_d = '0;
            i_d        = '0;
            j_d        = '0;
          end else begin
            state_d = SCAN;
            if (j_q == J_LAST) begin
              j_d = '0;
              i_d = i_q + 1'b1;
            end else begin
              j_d = j_q + 1'b1;
            end
          end
        end
      end
      default: state_d = LOAD;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= LOAD;
      load_cnt_q <= '0;
      i_q        <= '0;
      j_q        <= '0;
      l_q        <= '0;
      m_q        <= '0;
    end else begin
      state_q    <= state_d;
      load_cnt_q <= load_cnt_d;
      i_q        <= i_d;
      j_q        <= j_d;
      l_q        <= l_d;
      m_q        <= m_d;
    end
  end

  // Frame buffer is plain registers and is deliberately left uncleared by reset.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      fb_q[load_cnt_q] <= in_data;
    end
  end

  pool_max_acc #(
    .DEPTH(DEPTH)
  ) u_max_acc (
    .clk    (clk),
    .rst_n  (rst_n),
    .en     (acc_en),
    .start  (acc_start),
    .din    (fb_q[rd_addr]),
    .max_out(acc_max)
  );

  assign in_ready  = (state_q == LOAD);
  assign busy      = (state_q != LOAD);
  assign out_valid = (state_q == EMIT);
  assign out_data  = out_valid ? acc_max : '0;
  assign out_last  = out_valid && last_win;

endmodule

// File: tb/tb_pool_window_scheduler.sv
// Directed bench: ramp, all-0xFF and single-peak frames, output stall, mid-scan
// reset and gapped loading, all against hand-derived window maxima.
module tb_pool_window_scheduler;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_data;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_data;
  logic       out_last;
  logic       busy;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  localparam int M_RAMP = 0;
  localparam int M_FF   = 1;
  localparam int M_PEAK = 2;

  pool_window_scheduler dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .out_last (out_last),
    .busy     (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] pix(input int mode, input int x, input int y);
    case (mode)
      M_RAMP:  return 8'(y * 8 + x);
      M_FF:    return 8'hFF;
      default: return (x == 4 && y == 4) ? 8'hAA : 8'h00;
    endcase
  endfunction

  function automatic logic [7:0] expv(input int mode, input int i, input int j);
    case (mode)
      M_RAMP:  return 8'((j + 2) * 8 + i + 2);
      M_FF:    return 8'd255;
      default: return (i >= 2 && i <= 4 && j >= 2 && j <= 4) ? 8'hAA : 8'h00;
    endcase
  endfunction

  task automatic load_frame(input int mode, input bit gap);
    chk("load_in_ready", in_ready, 1);
    for (int p = 0; p < 64; p++) begin
      if (gap) begin
        in_valid = 1'b0;
        in_data  = 8'h5A;
        @(posedge clk); #1;
      end
      in_valid = 1'b1;
      in_data  = pix(mode, p % 8, p / 8);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    chk("scan_in_ready", in_ready, 0);
    chk("scan_busy", busy, 1);
  endtask

  task automatic collect(input int mode, input int nres, input int stall_at, input bit chk_period);
    int prev;
    prev = 0;
    for (int n = 0; n < nres; n++) begin
      int w;
      w = 0;
      out_ready = (n != stall_at);
      while (out_valid !== 1'b1 && w < 40) begin
        @(posedge clk); #1;
        w++;
      end
      chk($sformatf("valid_%0d", n), out_valid, 1);
      chk($sformatf("data_%0d", n), out_data, expv(mode, n / 6, n % 6));
      chk($sformatf("last_%0d", n), out_last, (n == 35) ? 1 : 0);
      if (chk_period && n > 0) chk($sformatf("period_%0d", n), cyc - prev, 10);
      prev = cyc;
      if (n == stall_at) begin
        for (int s = 0; s < 10; s++) begin
          @(posedge clk); #1;
          chk("stall_valid", out_valid, 1);
          chk("stall_data", out_data, expv(mode, n / 6, n % 6));
          chk("stall_last", out_last, 0);
        end
        out_ready = 1'b1;
      end
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
  endtask

  task automatic frame_done;
    chk("done_in_ready", in_ready, 1);
    chk("done_out_valid", out_valid, 0);
    chk("done_busy", busy, 0);
  endtask

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = 8'h00;
    out_ready = 1'b1;
    #12;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_out_last", out_last, 0);
    chk("rst_busy", busy, 0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;

    // Ramp frame with a 10-cycle stall on result 5.
    load_frame(M_RAMP, 1'b0);
    collect(M_RAMP, 36, 5, 1'b0);
    frame_done();

    // Saturated frame, back-to-back result spacing.
    load_frame(M_FF, 1'b0);
    collect(M_FF, 36, -1, 1'b1);
    frame_done();

    // Single peak at (4,4).
    load_frame(M_PEAK, 1'b0);
    collect(M_PEAK, 36, -1, 1'b0);
    frame_done();

    // Reset in the middle of window 7's scan.
    load_frame(M_RAMP, 1'b0);
    collect(M_RAMP, 7, -1, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    chk("pre_rst_busy", busy, 1);
    rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_in_ready", in_ready, 1);
    chk("midrst_busy", busy, 0);
    chk("midrst_out_data", out_data, 0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    load_frame(M_RAMP, 1'b0);
    collect(M_RAMP, 36, -1, 1'b0);
    frame_done();

    // Gapped loading must not change the results.
    load_frame(M_RAMP, 1'b1);
    collect(M_RAMP, 36, -1, 1'b0);
    frame_done();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
